// File: rtl/mult_div_unit_if.sv
// Decode/forwarding-side bundle for the multiply/divide unit: strobes and
// operands in, busy and live HI/LO out.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, hi_we, lo_we, rs_data, rt_data,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, hi_we, lo_we, rs_data, rt_data,
    output busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO (mult 5 cycles, div 10 cycles).
// Optional macro MDU_DIV0_HOLD_EN: divide by zero leaves HI/LO unchanged.
module mult_div_unit (
  input  logic            clk,
  input  logic            rst_n,
  mult_div_unit_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;

  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_nx_q, hi_nx_d, lo_nx_q, lo_nx_d;

  logic [63:0]        prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic signed [31:0] a_s, b_s, q_s, r_s;
  logic [31:0]        b_u, q_u, r_u;

  logic        op_valid;
  logic [3:0]  op_cyc;
  logic [31:0] res_hi, res_lo;

  // Operands sign/zero-extended to 64 bits so the product keeps its full width.
  assign prod_s = $signed({{32{bus.rs_data[31]}}, bus.rs_data}) *
                  $signed({{32{bus.rt_data[31]}}, bus.rt_data});
  assign prod_u = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};

  assign div_zero = (bus.rt_data == '0);
  assign div_ovf  = (bus.rs_data == 32'h8000_0000) && (bus.rt_data == '1);

  // Divisor forced to 1 in the special cases so the dividers never see x/0 or overflow.
  assign a_s = $signed(bus.rs_data);
  assign b_s = (div_zero || div_ovf) ? 32'sd1 : $signed(bus.rt_data);
  assign b_u = div_zero ? 32'd1 : bus.rt_data;
  assign q_s = a_s / b_s;
  assign r_s = a_s % b_s;
  assign q_u = bus.rs_data / b_u;
  assign r_u = bus.rs_data % b_u;

  always_comb begin
    op_valid = 1'b0;
    op_cyc   = '0;
    res_hi   = '0;
    res_lo   = '0;
    case (bus.op)
      OP_MULT: begin
        op_valid         = 1'b1;
        op_cyc           = MULT_CYC;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        op_valid         = 1'b1;
        op_cyc           = MULT_CYC;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        op_valid = 1'b1;
        op_cyc   = DIV_CYC;
        if (div_zero) begin
`ifdef MDU_DIV0_HOLD_EN
          res_hi = hi_q;
          res_lo = lo_q;
`else
          res_hi = bus.rs_data;
          res_lo = '1;
`endif
        end else if (bus.op == OP_DIVU) begin
          res_hi = r_u;
          res_lo = q_u;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_nx_d = hi_nx_q;
    lo_nx_d = lo_nx_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (op_valid) begin
            hi_nx_d = res_hi;
            lo_nx_d = res_lo;
            count_d = op_cyc;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end else begin
          if (bus.hi_we) hi_d = bus.rs_data;
          if (bus.lo_we) lo_d = bus.rs_data;
        end
      end
      RUN: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          hi_d    = hi_nx_q;
          lo_d    = lo_nx_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_nx_q <= '0;
      lo_nx_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_nx_q <= hi_nx_d;
      lo_nx_q <= lo_nx_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
